// File: rtl/alarma_multi.sv
// alarma_multi: multi-slot BCD alarm controller.
// Loads N_ALARMS alarm times from framed ASCII bytes ("S<slot>HHMMSS\n" sets a slot,
// "C<slot>\n" clears it). When the running time matches an enabled slot it rings. The ring
// can be snoozed or dismissed by the debounced sensor, and it auto-dismisses after RING_SECS
// seconds. While ringing it drives a ramping PWM duty word.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset (release synchronised)
//   rx_data, rx_valid     received byte and its one-cycle strobe
//   Hora_actual           current time, BCD HH:MM:SS
//   sensores              asynchronous user/presence sensor
//   Activada              any slot enabled or snooze pending
//   Sonando               ringing
//   accion                00 idle, 01 ringing, 10 snoozed, 11 dismissed (one cycle)
//   dutty                 PWM duty word
//   done, err             one-cycle frame accepted / rejected pulses
//   slot_ring             slot that caused the current ring/snooze
module alarma_multi #(
    parameter int unsigned N_ALARMS   = 4,
    parameter int unsigned SNOOZE_MIN = 5,
    parameter int unsigned MAX_SNOOZE = 3,
    parameter int unsigned RING_SECS  = 60,
    parameter logic [15:0] DUTY_STEP  = 16'h0800,
    parameter int unsigned DEB_CYC    = 500_000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    input  logic [23:0] Hora_actual,
    input  logic        sensores,
    output logic        Activada,
    output logic        Sonando,
    output logic [1:0]  accion,
    output logic [15:0] dutty,
    output logic        done,
    output logic        err,
    output logic [2:0]  slot_ring
);
    localparam int unsigned DW = $clog2(DEB_CYC + 1);
    localparam logic [DW-1:0] DebMax = DW'(DEB_CYC);
    localparam logic [7:0] SlotLim = 8'(48 + N_ALARMS);

    typedef enum logic [1:0] {StIdle, StRing, StSnooze} ctl_e;
    typedef enum logic [1:0] {PsIdle, PsSlot, PsDigit, PsEnd} ps_e;

    function automatic logic [6:0] bcd2bin(input logic [7:0] b);
        return 7'(b[7:4]) * 7'd10 + 7'(b[3:0]);
    endfunction

    function automatic logic [7:0] bin2bcd(input logic [6:0] v);
        return {4'(v / 7'd10), 4'(v % 7'd10)};
    endfunction

    // Reset asserts immediately, releases two clocks later.
    logic [1:0] rst_sync_q;
    logic       rst_int_n;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rst_sync_q <= 2'b00;
        else        rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
    assign rst_int_n = rst_sync_q[1];

    // ---------------- state ----------------
    ctl_e             state_q, state_d;
    ps_e              ps_q, ps_d;
    logic [23:0]      hora_q, hora_prev_q, target_q, target_d, time_q, time_d;
    logic [15:0]      dutty_q, dutty_d;
    logic [7:0]       ring_cnt_q, ring_cnt_d, snz_cnt_q, snz_cnt_d;
    logic [2:0]       slot_ring_q, slot_ring_d, slot_q, slot_d, idx_q, idx_d;
    logic             dism_q, dism_d, done_q, done_d, err_q, err_d, op_set_q, op_set_d;
    logic [1:0]       sens_sync_q;
    logic             deb_q, deb_d;
    logic [DW-1:0]    deb_cnt_q, deb_cnt_d;
    logic [N_ALARMS-1:0] slot_en_q;
    logic [23:0]      slot_time_q [N_ALARMS];

    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            state_q     <= StIdle;
            ps_q        <= PsIdle;
            hora_q      <= '0;
            hora_prev_q <= '0;
            target_q    <= '0;
            time_q      <= '0;
            dutty_q     <= '0;
            ring_cnt_q  <= '0;
            snz_cnt_q   <= '0;
            slot_ring_q <= '0;
            slot_q      <= '0;
            idx_q       <= '0;
            dism_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            op_set_q    <= 1'b0;
            sens_sync_q <= 2'b00;
            deb_q       <= 1'b0;
            deb_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            ps_q        <= ps_d;
            hora_q      <= Hora_actual;
            hora_prev_q <= hora_q;
            target_q    <= target_d;
            time_q      <= time_d;
            dutty_q     <= dutty_d;
            ring_cnt_q  <= ring_cnt_d;
            snz_cnt_q   <= snz_cnt_d;
            slot_ring_q <= slot_ring_d;
            slot_q      <= slot_d;
            idx_q       <= idx_d;
            dism_q      <= dism_d;
            done_q      <= done_d;
            err_q       <= err_d;
            op_set_q    <= op_set_d;
            sens_sync_q <= {sens_sync_q[0], sensores};
            deb_q       <= deb_d;
            deb_cnt_q   <= deb_cnt_d;
        end
    end

    // ---------------- sensor debounce ----------------
    logic sens_rise;
    always_comb begin
        deb_d     = deb_q;
        deb_cnt_d = deb_cnt_q;
        sens_rise = 1'b0;
        if (sens_sync_q[1] == deb_q) begin
            deb_cnt_d = '0;
        end else if (deb_cnt_q == DebMax) begin
            deb_d     = sens_sync_q[1];
            deb_cnt_d = '0;
            sens_rise = sens_sync_q[1];
        end else begin
            deb_cnt_d = deb_cnt_q + DW'(1);
        end
    end

    // ---------------- frame parser ----------------
    logic wr_set, wr_clr, is_dig, lim_ok;
    always_comb begin
        is_dig = (rx_data >= 8'h30) && (rx_data <= 8'h39);
        case (idx_q)
            3'd0:       lim_ok = rx_data[3:0] <= 4'd2;
            3'd1:       lim_ok = (time_q[3:0] != 4'd2) || (rx_data[3:0] <= 4'd3);
            3'd2, 3'd4: lim_ok = rx_data[3:0] <= 4'd5;
            default:    lim_ok = 1'b1;
        endcase
    end

    always_comb begin
        ps_d     = ps_q;
        op_set_d = op_set_q;
        slot_d   = slot_q;
        time_d   = time_q;
        idx_d    = idx_q;
        done_d   = 1'b0;
        err_d    = 1'b0;
        wr_set   = 1'b0;
        wr_clr   = 1'b0;
        if (rx_valid) begin
            case (ps_q)
                PsIdle: begin
                    if (rx_data == 8'h53) begin
                        op_set_d = 1'b1;
                        ps_d     = PsSlot;
                    end else if (rx_data == 8'h43) begin
                        op_set_d = 1'b0;
                        ps_d     = PsSlot;
                    end else begin
                        err_d = 1'b1;
                    end
                end
                PsSlot: begin
                    if (rx_data >= 8'h30 && rx_data < SlotLim) begin
                        slot_d = rx_data[2:0];
                        idx_d  = '0;
                        ps_d   = op_set_q ? PsDigit : PsEnd;
                    end else begin
                        err_d = 1'b1;
                        ps_d  = PsIdle;
                    end
                end
                PsDigit: begin
                    if (is_dig && lim_ok) begin
                        time_d = {time_q[19:0], rx_data[3:0]};
                        idx_d  = idx_q + 3'd1;
                        if (idx_q == 3'd5) ps_d = PsEnd;
                    end else begin
                        err_d = 1'b1;
                        ps_d  = PsIdle;
                    end
                end
                default: begin
                    ps_d = PsIdle;
                    if (rx_data == 8'h0A) begin
                        done_d = 1'b1;
                        wr_set = op_set_q;
                        wr_clr = !op_set_q;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            slot_en_q <= '0;
            for (int i = 0; i < int'(N_ALARMS); i++) slot_time_q[i] <= '0;
        end else begin
            for (int i = 0; i < int'(N_ALARMS); i++) begin
                if (slot_q == 3'(i)) begin
                    if (wr_set) begin
                        slot_time_q[i] <= time_q;
                        slot_en_q[i]   <= 1'b1;
                    end else if (wr_clr) begin
                        slot_en_q[i]   <= 1'b0;
                    end
                end
            end
        end
    end

    // ---------------- alarm matching and snooze target ----------------
    logic       sec_evt, hit;
    logic [2:0] hit_idx;
    assign sec_evt = hora_q != hora_prev_q;

    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        // Descending scan so the lowest matching index is the one that sticks.
        for (int i = int'(N_ALARMS) - 1; i >= 0; i--) begin
            if (slot_en_q[i] && slot_time_q[i] == hora_q) begin
                hit     = 1'b1;
                hit_idx = 3'(i);
            end
        end
    end

    logic [6:0]  mm_sum, hh_sum;
    logic [23:0] snz_target;
    always_comb begin
        mm_sum = bcd2bin(hora_q[15:8]) + 7'(SNOOZE_MIN);
        hh_sum = bcd2bin(hora_q[23:16]);
        if (mm_sum >= 7'd60) begin
            mm_sum = mm_sum - 7'd60;
            hh_sum = hh_sum + 7'd1;
        end
        if (hh_sum >= 7'd24) hh_sum = '0;
        snz_target = {bin2bcd(hh_sum), bin2bcd(mm_sum), hora_q[7:0]};
    end

    // ---------------- controller next state ----------------
    logic [16:0] duty_sum;
    logic        clr_ring;
    assign duty_sum = {1'b0, dutty_q} + {1'b0, DUTY_STEP};
    assign clr_ring = wr_clr && (slot_q == slot_ring_q);

    always_comb begin
        state_d     = state_q;
        dutty_d     = dutty_q;
        ring_cnt_d  = ring_cnt_q;
        snz_cnt_d   = snz_cnt_q;
        target_d    = target_q;
        slot_ring_d = slot_ring_q;
        dism_d      = 1'b0;
        case (state_q)
            StIdle: begin
                if (sec_evt && hit) begin
                    state_d     = StRing;
                    slot_ring_d = hit_idx;
                    dutty_d     = DUTY_STEP;
                    ring_cnt_d  = '0;
                    snz_cnt_d   = '0;
                end
            end
            StRing: begin
                if (clr_ring) begin
                    dism_d = 1'b1;
                end else if (sens_rise) begin
                    if (snz_cnt_q < 8'(MAX_SNOOZE)) begin
                        state_d   = StSnooze;
                        snz_cnt_d = snz_cnt_q + 8'd1;
                        target_d  = snz_target;
                        dutty_d   = '0;
                    end else begin
                        dism_d = 1'b1;
                    end
                end else if (sec_evt) begin
                    dutty_d    = duty_sum[16] ? 16'hFFFF : duty_sum[15:0];
                    ring_cnt_d = ring_cnt_q + 8'd1;
                    if (ring_cnt_q + 8'd1 == 8'(RING_SECS)) dism_d = 1'b1;
                end
            end
            StSnooze: begin
                if (clr_ring) begin
                    dism_d = 1'b1;
                end else if (sec_evt && hora_q == target_q) begin
                    state_d    = StRing;
                    dutty_d    = DUTY_STEP;
                    ring_cnt_d = '0;
                end
            end
            default: state_d = StIdle;
        endcase
        if (dism_d) begin
            state_d = StIdle;
            dutty_d = '0;
        end
    end

    // ---------------- outputs ----------------
    always_comb begin
        Sonando   = state_q == StRing;
        Activada  = (|slot_en_q) || (state_q == StSnooze);
        dutty     = dutty_q;
        done      = done_q;
        err       = err_q;
        slot_ring = slot_ring_q;
        if (dism_q)                  accion = 2'b11;
        else if (state_q == StRing)  accion = 2'b01;
        else if (state_q == StSnooze) accion = 2'b10;
        else                         accion = 2'b00;
    end
endmodule
